// File: rtl/pentarv_pkg.sv
// pentarv_pkg: shared decode-stage definitions for the pentaRV core.
// Holds the immediate-format select encodings, the opcodes the immediate
// unit cares about, the widest datapath type and a sign-extension helper.
package pentarv_pkg;

  // Immediate format select encodings (imm_sel_d)
  localparam logic [2:0] IMM_I   = 3'b000;
  localparam logic [2:0] IMM_B   = 3'b001;
  localparam logic [2:0] IMM_J   = 3'b010;
  localparam logic [2:0] IMM_S   = 3'b011;
  localparam logic [2:0] IMM_U   = 3'b100;
  localparam logic [2:0] IMM_Z   = 3'b101;
  localparam logic [2:0] IMM_SH  = 3'b110;
  localparam logic [2:0] IMM_RSV = 3'b111;

  // Major opcodes
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  // Widest supported datapath
  localparam int unsigned XLEN_MAX = 64;
  typedef logic [XLEN_MAX-1:0] xlen_t;

  // Sign-extend a 32-bit value to the widest datapath
  function automatic xlen_t sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/imm_extract.sv
// imm_extract: combinational immediate extraction and extension.
// Ports:
//   instr [31:7]  instruction bits that carry immediate fields (opcode not needed)
//   sel   [2:0]   format select (IMM_* encodings)
//   imm   [XLEN]  extended immediate, 0 for the reserved select
//   err           high when the reserved select is used
// Kept free of pipeline state so a compressed-expander stage can reuse it.
module imm_extract
  import pentarv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     instr,
  input  logic [2:0]      sel,
  output logic [XLEN-1:0] imm,
  output logic            err
);

  // Format decode; replication counts are sized from XLEN so both widths
  // build without zero-width concatenations (U fills from bit 31 upward).
  always_comb begin
    imm = '0;
    err = 1'b0;
    case (sel)
      IMM_I:   imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      IMM_J:   imm = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20],
                      instr[30:21], 1'b0};
      IMM_U:   imm = {{(XLEN-31){instr[31]}}, instr[30:12], 12'h000};
      IMM_Z:   imm = {{(XLEN-5){1'b0}}, instr[19:15]};
      IMM_SH: begin
        // RV64 shifts use a 6-bit shamt, RV32 only 5 bits
        if (XLEN == 64) begin
          imm = {{(XLEN-6){1'b0}}, instr[25:20]};
        end else begin
          imm = {{(XLEN-5){1'b0}}, instr[24:20]};
        end
      end
      IMM_RSV: begin
        imm = '0;
        err = 1'b1;
      end
      default: begin
        imm = '0;
        err = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/imm_stage.sv
// imm_stage: decode-stage immediate unit with D->E pipeline register and
// LUI+ADDI constant-pair fusion detection.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   instr_d, imm_sel_d        decode instruction and immediate format select
//   valid_d                   decode slot holds a real instruction
//   stall_e, flush_e          hold / bubble the E-stage register (flush wins)
//   imm_e, imm_valid_e        registered immediate and slot valid
//   imm_err_e                 E instruction used the reserved select
//   fuse_e, fuse_imm_e        E instruction is an ADDI completing a LUI pair,
//                             with the fused constant (0 when not fusing)
module imm_stage
  import pentarv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit FUSE_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr_d,
  input  logic [2:0]      imm_sel_d,
  input  logic            valid_d,
  input  logic            stall_e,
  input  logic            flush_e,
  output logic [XLEN-1:0] imm_e,
  output logic            imm_valid_e,
  output logic            imm_err_e,
  output logic            fuse_e,
  output logic [XLEN-1:0] fuse_imm_e
);

  logic [XLEN-1:0] ext_imm_s;
  logic            ext_err_s;
  logic [6:0]      opcode_s;
  logic [4:0]      rd_s;
  logic [4:0]      rs1_s;
  logic [2:0]      funct3_s;
  logic [XLEN-1:0] addi_imm_s;
  logic [XLEN-1:0] lui_ext_s;
  logic [XLEN-1:0] fuse_sum_s;
  logic            pair_hit_s;

  // Tracker: the low 12 bits of a LUI value are always zero, so only the
  // upper 20 bits are stored.
  logic            lui_vld_r;
  logic [4:0]      lui_rd_r;
  logic [31:12]    lui_hi_r;

  imm_extract #(.XLEN(XLEN)) u_extract (
    .instr (instr_d[31:7]),
    .sel   (imm_sel_d),
    .imm   (ext_imm_s),
    .err   (ext_err_s)
  );

  assign opcode_s   = instr_d[6:0];
  assign rd_s       = instr_d[11:7];
  assign funct3_s   = instr_d[14:12];
  assign rs1_s      = instr_d[19:15];
  // The ADDI half of a pair always contributes its I-immediate, whatever
  // format the decoder selected for the shared imm_e path.
  assign addi_imm_s = {{(XLEN-12){instr_d[31]}}, instr_d[31:20]};
  assign lui_ext_s  = {{(XLEN-31){lui_hi_r[31]}}, lui_hi_r[30:12], 12'h000};
  assign fuse_sum_s = lui_ext_s + addi_imm_s;

  // Pair match against the tracked LUI; accept qualification is applied at load
  always_comb begin
    pair_hit_s = 1'b0;
    if (FUSE_EN && lui_vld_r && (opcode_s == OP_IMM) && (funct3_s == 3'b000) &&
        (rd_s == rs1_s) && (rd_s == lui_rd_r) && (rd_s != 5'd0)) begin
      pair_hit_s = 1'b1;
    end else begin
      pair_hit_s = 1'b0;
    end
  end

  // LUI tracker: set on an accepted LUI, cleared by any other accepted slot
  always_ff @(posedge clk) begin
    if (rst || flush_e) begin
      lui_vld_r <= 1'b0;
      lui_rd_r  <= 5'd0;
      lui_hi_r  <= 20'h00000;
    end else if (stall_e) begin
      lui_vld_r <= lui_vld_r;
      lui_rd_r  <= lui_rd_r;
      lui_hi_r  <= lui_hi_r;
    end else if (FUSE_EN && valid_d && (opcode_s == OP_LUI)) begin
      lui_vld_r <= 1'b1;
      lui_rd_r  <= rd_s;
      lui_hi_r  <= instr_d[31:12];
    end else begin
      lui_vld_r <= 1'b0;
      lui_rd_r  <= lui_rd_r;
      lui_hi_r  <= lui_hi_r;
    end
  end

  // D->E register: reset and flush load a bubble, stall holds
  always_ff @(posedge clk) begin
    if (rst || flush_e) begin
      imm_e       <= '0;
      imm_valid_e <= 1'b0;
      imm_err_e   <= 1'b0;
      fuse_e      <= 1'b0;
      fuse_imm_e  <= '0;
    end else if (stall_e) begin
      imm_e       <= imm_e;
      imm_valid_e <= imm_valid_e;
      imm_err_e   <= imm_err_e;
      fuse_e      <= fuse_e;
      fuse_imm_e  <= fuse_imm_e;
    end else begin
      imm_e       <= ext_imm_s;
      imm_valid_e <= valid_d;
      imm_err_e   <= ext_err_s & valid_d;
      fuse_e      <= pair_hit_s & valid_d;
      fuse_imm_e  <= (pair_hit_s && valid_d) ? fuse_sum_s : '0;
    end
  end

endmodule

// File: tb/tb_imm_stage.sv
// tb_imm_stage: scoreboard bench driving one XLEN=32 and one XLEN=64
// instance of imm_stage with the same stimulus.
module tb_imm_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_d;
  logic [2:0]  imm_sel_d;
  logic        valid_d, stall_e, flush_e;

  logic [31:0] imm32, fimm32;
  logic        vld32, err32, fuse32;
  logic [63:0] imm64, fimm64;
  logic        vld64, err64, fuse64;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] imm32;
    logic [63:0] imm64;
    logic [63:0] fimm32;
    logic [63:0] fimm64;
    logic        vld;
    logic        err;
    logic        fuse;
  } exp_t;

  exp_t q[$];
  exp_t prev;
  logic        m_vld;
  logic [4:0]  m_rd;
  logic [31:0] m_lui;

  always #5 clk = ~clk;

  imm_stage #(.XLEN(32), .FUSE_EN(1'b1)) dut32 (
    .clk(clk), .rst(rst), .instr_d(instr_d), .imm_sel_d(imm_sel_d),
    .valid_d(valid_d), .stall_e(stall_e), .flush_e(flush_e),
    .imm_e(imm32), .imm_valid_e(vld32), .imm_err_e(err32),
    .fuse_e(fuse32), .fuse_imm_e(fimm32));

  imm_stage #(.XLEN(64), .FUSE_EN(1'b1)) dut64 (
    .clk(clk), .rst(rst), .instr_d(instr_d), .imm_sel_d(imm_sel_d),
    .valid_d(valid_d), .stall_e(stall_e), .flush_e(flush_e),
    .imm_e(imm64), .imm_valid_e(vld64), .imm_err_e(err64),
    .fuse_e(fuse64), .fuse_imm_e(fimm64));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference immediate, built with signed arithmetic straight from the field layout
  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] sel,
                                          input bit is64);
    longint t;
    case (sel)
      3'd0: t = $signed(ins[31:20]);
      3'd1: t = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
      3'd2: t = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
      3'd3: t = $signed({ins[31:25], ins[11:7]});
      3'd4: t = $signed({ins[31:12], 12'h000});
      3'd5: t = 64'(ins[19:15]);
      3'd6: t = is64 ? 64'(ins[25:20]) : 64'(ins[24:20]);
      default: t = 64'd0;
    endcase
    if (is64) return t;
    else return {32'h0, t[31:0]};
  endfunction

  // Drive one cycle, predict its E outputs, then compare after the edge
  task automatic step(input logic [31:0] ins, input logic [2:0] sel,
                      input logic v, input logic st, input logic fl, input logic r);
    exp_t e;
    longint sum;
    logic hit;
    instr_d = ins; imm_sel_d = sel; valid_d = v; stall_e = st; flush_e = fl; rst = r;
    hit = m_vld && ins[6:0] == 7'h13 && ins[14:12] == 3'd0 && ins[11:7] == ins[19:15] &&
          ins[11:7] == m_rd && ins[11:7] != 5'd0;
    sum = longint'($signed(m_lui)) + longint'($signed(ins[31:20]));
    if (r || fl) begin
      e = '{64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0};
    end else if (st) begin
      e = prev;
    end else begin
      e.imm32  = ref_imm(ins, sel, 1'b0);
      e.imm64  = ref_imm(ins, sel, 1'b1);
      e.vld    = v;
      e.err    = v && sel == 3'd7;
      e.fuse   = v && hit;
      e.fimm64 = e.fuse ? sum : 64'd0;
      e.fimm32 = e.fuse ? {32'h0, sum[31:0]} : 64'd0;
    end
    prev = e;
    q.push_back(e);
    if (r || fl) m_vld = 1'b0;
    else if (st) m_vld = m_vld;
    else if (v && ins[6:0] == 7'h37) begin
      m_vld = 1'b1; m_rd = ins[11:7]; m_lui = {ins[31:12], 12'h000};
    end else m_vld = 1'b0;
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      chk("scoreboard_empty", 64'd0, 64'd1);
    end else begin
      e = q.pop_front();
      chk("imm32",  {32'h0, imm32},  e.imm32);
      chk("imm64",  imm64,           e.imm64);
      chk("fimm32", {32'h0, fimm32}, e.fimm32);
      chk("fimm64", fimm64,          e.fimm64);
      chk("vld32",  64'(vld32),  64'(e.vld));
      chk("vld64",  64'(vld64),  64'(e.vld));
      chk("err32",  64'(err32),  64'(e.err));
      chk("err64",  64'(err64),  64'(e.err));
      chk("fuse32", 64'(fuse32), 64'(e.fuse));
      chk("fuse64", 64'(fuse64), 64'(e.fuse));
    end
  endtask

  localparam logic [31:0] LUI5  = 32'h123452B7;
  localparam logic [31:0] ADDI5 = 32'h67828293;

  initial begin
    logic [31:0] ins;
    m_vld = 1'b0; m_rd = 5'd0; m_lui = 32'h0;
    prev = '{64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0};
    rst = 1'b1; instr_d = 32'h0; imm_sel_d = 3'd0; valid_d = 1'b0;
    stall_e = 1'b0; flush_e = 1'b0;

    step(32'hFFFFFFFF, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(32'hFFFFFFFF, 3'd7, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("rst_imm", imm64, 64'd0);
    chk("rst_vld", 64'(vld32), 64'd0);

    step(32'hFFF00093, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("i_lit", {32'h0, imm32}, 64'hFFFFFFFF);
    step(32'hFE000EE3, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("b_lit", {32'h0, imm32}, 64'hFFFFFFFC);
    chk("b_vld", 64'(vld32), 64'd1);

    step(LUI5, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    step(ADDI5, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("fuse_lit", {32'h0, fimm32}, 64'h12345678);
    chk("fuse_on", 64'(fuse32), 64'd1);
    step(LUI5, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    step(32'hFFF28293, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("fuse_neg_lit", {32'h0, fimm32}, 64'h12344FFF);

    // pair breaks: flush between, rd mismatch, x0 destination, reset between
    step(LUI5, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    step(32'h0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(ADDI5, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("brk_flush", 64'(fuse32), 64'd0);
    step(LUI5, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    step(32'h67828313, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("brk_rd", 64'(fuse64), 64'd0);
    step(32'h12345037, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    step(32'h67800013, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("brk_x0", 64'(fuse32), 64'd0);
    step(LUI5, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    step(32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(ADDI5, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("brk_rst", 64'(fuse32), 64'd0);

    // stalled ADDI fuses once accepted; back-to-back LUI replaces value
    step(32'h0000A2B7, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    step(LUI5, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    step(ADDI5, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(ADDI5, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(ADDI5, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("stall_fuse_lit", fimm64, 64'h12345678);

    // stall hold, then stall+flush
    step(32'h00500093, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step($urandom, 3'(i), 1'b1, 1'b1, 1'b0, 1'b0);
    chk("stall_lit", {32'h0, imm32}, 64'd5);
    step(32'hFFF00093, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("stflush_imm", imm64, 64'd0);
    chk("stflush_vld", 64'(vld64), 64'd0);

    // reserved select
    step(32'hFFFFFFFF, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rsv_err", 64'(err32), 64'd1);
    chk("rsv_imm", imm64, 64'd0);
    step(32'hFFFFFFFF, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rsv_inv_err", 64'(err64), 64'd0);

    // wide forms
    step(32'h800000B7, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("u64_lit", imm64, 64'hFFFFFFFF80000000);
    step(32'h03F00013, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("sh64_lit", imm64, 64'h3F);
    chk("sh32_lit", {32'h0, imm32}, 64'h1F);
    step(32'h000F8073, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("z64_lit", imm64, 64'h1F);
    step(32'hFFF00093, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("rst_mid_imm", imm64, 64'd0);
    chk("rst_mid_vld", 64'(vld64), 64'd0);

    // random mix biased toward LUI/ADDI pairs
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(2, 0))
        0: ins = {$urandom_range(32'hFFFFF, 0) , 12'h000} >> 0 | {20'h0, 2'b0, 3'($urandom_range(3, 0)), 7'h37};
        1: begin
          ins = {12'($urandom), 5'd0, 3'd0, 5'd0, 7'h13};
          ins[11:7]  = 5'($urandom_range(3, 0));
          ins[19:15] = ($urandom_range(3, 0) == 0) ? 5'($urandom_range(3, 0)) : ins[11:7];
        end
        default: ins = $urandom;
      endcase
      step(ins, 3'($urandom_range(7, 0)), 1'($urandom_range(9, 0) != 0),
           1'($urandom_range(4, 0) == 0), 1'($urandom_range(9, 0) == 0),
           1'($urandom_range(29, 0) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
